// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst write arbiter in front of one synchronous FIFO
//
// Shares a single FIFO write port between NUM_REQ producers. In IDLE the first
// valid requester at or after rr_ptr (modulo NUM_REQ) is granted; in BURST the
// granted producer writes up to MAX_BURST words straight into the FIFO, stalling
// on fifo_full. A burst ends on reaching MAX_BURST words or when the owner drops
// req_valid; rr_ptr then moves to the index after the owner.
//
// Optional feature macro: FIFO_ARB_STATS_EN adds per-requester 16-bit saturating
// accepted-word counters on word_cnt.
//
// Ports:
//   clk        in   single clock shared with the FIFO and producers
//   srst       in   synchronous active-high reset
//   req_valid  in   [NUM_REQ]         requester i has a word on its slice
//   req_data   in   [NUM_REQ*DATA_W]  requester i word at [i*DATA_W +: DATA_W]
//   req_ready  out  [NUM_REQ]         word i accepted when valid & ready
//   fifo_full  in   FIFO full flag
//   fifo_din   out  [DATA_W]  FIFO din (0 when not writing)
//   fifo_wr_en out  FIFO wr_en
//   grant      out  [NUM_REQ] registered one-hot owner, 0 when idle
//   busy       out  high in BURST
//   word_cnt   out  [NUM_REQ*16] per-requester counters (FIFO_ARB_STATS_EN only)

module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                      clk,
   input  logic                      srst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      fifo_full,
   output logic [DATA_W-1:0]         fifo_din,
   output logic                      fifo_wr_en,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      busy
`ifdef FIFO_ARB_STATS_EN
   ,
   output logic [NUM_REQ*16-1:0]     word_cnt
`endif
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]   g_idx_q, g_idx_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [3:0]         burst_cnt_q, burst_cnt_d;

   logic               pick_found;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W-1:0]   g_next;
   logic               g_valid;
   logic               xfer;

   // Rotating priority scan starting at rr_ptr.
   always_comb begin
      int               j;
      logic [IDX_W-1:0] cand;
      j          = 0;
      cand       = '0;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(rr_ptr_q) + k;
         if (j >= NUM_REQ) j = j - NUM_REQ;
         cand = IDX_W'(j);
         if (!pick_found && req_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      int jn;
      jn = int'(g_idx_q) + 1;
      if (jn >= NUM_REQ) jn = 0;
      g_next = IDX_W'(jn);
   end

   assign busy    = (state_q == S_BURST);
   assign grant   = grant_q;
   assign g_valid = req_valid[g_idx_q];
   // srst is folded in so that no write can slip out in the reset cycle itself.
   assign xfer    = busy & g_valid & ~fifo_full & ~srst;

   always_comb begin
      req_ready = '0;
      if (busy && !fifo_full && !srst) req_ready[g_idx_q] = 1'b1;
   end

   assign fifo_wr_en = xfer;
   assign fifo_din   = xfer ? req_data[g_idx_q*DATA_W +: DATA_W] : '0;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      g_idx_d     = g_idx_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               state_d           = S_BURST;
               grant_d           = '0;
               grant_d[pick_idx] = 1'b1;
               g_idx_d           = pick_idx;
               burst_cnt_d       = '0;
            end
         end
         S_BURST: begin
            // A dropped valid ends the burst even if nothing was written yet;
            // rr_ptr still advances so the dropper loses its turn.
            if (!g_valid || (xfer && (burst_cnt_q + 4'd1 == 4'(MAX_BURST)))) begin
               state_d     = S_IDLE;
               grant_d     = '0;
               rr_ptr_d    = g_next;
               burst_cnt_d = '0;
            end else if (xfer) begin
               burst_cnt_d = burst_cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         g_idx_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         g_idx_q     <= g_idx_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] cnt_q [NUM_REQ];

   always_ff @(posedge clk) begin
      if (srst) begin
         for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (xfer && (g_idx_q == IDX_W'(i)) && (cnt_q[i] != 16'hFFFF))
               cnt_q[i] <= cnt_q[i] + 16'd1;
         end
      end
   end

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word_cnt
      assign word_cnt[gi*16 +: 16] = cnt_q[gi];
   end
`endif

endmodule
